// File: rtl/glb_feeder_pkg.sv
// Shared types and sizing for the GLB-to-PE-array feeder.
package glb_feeder_pkg;

  typedef enum logic [1:0] {
    IFMAP  = 2'd0,
    FILTER = 2'd1,
    IPSUM  = 2'd2,
    NONE   = 2'd3
  } stream_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_BITS   = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/glb_skid_fifo.sv
// Two-entry FIFO holding {data, tag_X, tag_Y} between the SRAM read port and the PE channel.
module glb_skid_fifo
  import glb_feeder_pkg::*;
#(
  parameter int W = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [W-1:0]        push_data,
  input  logic                pop,
  output logic [CNT_BITS-1:0] count,
  output logic                empty,
  output logic [W-1:0]        head
);

  logic [W-1:0]        mem_q [FIFO_DEPTH];
  logic [0:0]          wr_ptr_q;
  logic [0:0]          rd_ptr_q;
  logic [CNT_BITS-1:0] count_q;

  // The top never pushes into a full FIFO nor pops an empty one, so no guards here.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_BITS'(push) - CNT_BITS'(pop);
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/glb_pe_feeder.sv
// Reads a (y, x, word) block from a GLB bank and streams it, tagged, onto one PE-array input channel.
module glb_pe_feeder
  import glb_feeder_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int XID_BITS  = 4,
  parameter int YID_BITS  = 4,
  parameter int ADDR_BITS = 16,
  parameter int WCNT_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_type,
  input  logic [ADDR_BITS-1:0] cmd_base_addr,
  input  logic [XID_BITS-1:0]  cmd_num_x,
  input  logic [YID_BITS-1:0]  cmd_num_y,
  input  logic [WCNT_BITS-1:0] cmd_words,
  input  logic [XID_BITS-1:0]  cmd_tag_x0,
  input  logic [YID_BITS-1:0]  cmd_tag_y0,
  output logic                 sram_ren,
  output logic [ADDR_BITS-1:0] sram_addr,
  input  logic [DATA_SIZE-1:0] sram_rdata,
  output logic                 GLB_ifmap_valid,
  input  logic                 GLB_ifmap_ready,
  output logic                 GLB_filter_valid,
  input  logic                 GLB_filter_ready,
  output logic                 GLB_ipsum_valid,
  input  logic                 GLB_ipsum_ready,
  output logic [DATA_SIZE-1:0] GLB_data_in,
  output logic [XID_BITS-1:0]  ifmap_tag_X,
  output logic [XID_BITS-1:0]  filter_tag_X,
  output logic [XID_BITS-1:0]  ipsum_tag_X,
  output logic [YID_BITS-1:0]  ifmap_tag_Y,
  output logic [YID_BITS-1:0]  filter_tag_Y,
  output logic [YID_BITS-1:0]  ipsum_tag_Y,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           dbg_state
);

  // Handshakes: a word moves when valid && ready on the selected channel in the same cycle;
  // once valid rises, data/tags/valid hold until that transfer; ready may toggle freely.

  localparam int FW = DATA_SIZE + XID_BITS + YID_BITS;

  state_e               state_q, state_d;
  stream_e              type_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [XID_BITS-1:0]  num_x_q, x0_q, xi_q, ptag_x_q;
  logic [YID_BITS-1:0]  num_y_q, y0_q, yi_q, ptag_y_q;
  logic [WCNT_BITS-1:0] words_q, wi_q;
  logic                 inflight_q;

  logic                 accept;
  logic                 pop;
  logic                 sel_ready;
  logic                 sel_valid;
  logic                 last_w, last_x, last_y, last_read;
  logic [CNT_BITS:0]    occ, limit;
  logic [CNT_BITS-1:0]  fifo_count;
  logic                 fifo_empty;
  logic [FW-1:0]        fifo_head;
  logic [DATA_SIZE-1:0] head_data;
  logic [XID_BITS-1:0]  head_x;
  logic [YID_BITS-1:0]  head_y;

  glb_skid_fifo #(.W(FW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({sram_rdata, ptag_x_q, ptag_y_q}),
    .pop       (pop),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign {head_data, head_x, head_y} = fifo_head;

  always_comb begin
    sel_ready = 1'b0;
    case (type_q)
      IFMAP:   sel_ready = GLB_ifmap_ready;
      FILTER:  sel_ready = GLB_filter_ready;
      IPSUM:   sel_ready = GLB_ipsum_ready;
      default: sel_ready = 1'b0;
    endcase
  end

  assign sel_valid = !fifo_empty && (type_q != NONE);
  assign pop       = sel_valid && sel_ready;

  // A slot freed by this cycle's pop is usable by this cycle's read.
  assign occ      = {1'b0, fifo_count} + {{CNT_BITS{1'b0}}, inflight_q};
  assign limit    = (CNT_BITS+1)'(FIFO_DEPTH) + {{CNT_BITS{1'b0}}, pop};
  assign sram_ren = (state_q == S_RUN) && (occ < limit);
  assign sram_addr = sram_ren ? addr_q : '0;

  assign last_w    = (wi_q == words_q - WCNT_BITS'(1));
  assign last_x    = (xi_q == num_x_q - XID_BITS'(1));
  assign last_y    = (yi_q == num_y_q - YID_BITS'(1));
  assign last_read = sram_ren && last_w && last_x && last_y;

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept = 1'b1;
          if ((cmd_type == 2'd3) || (cmd_num_x == '0) || (cmd_num_y == '0) || (cmd_words == '0))
            state_d = S_DONE;
          else
            state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_read) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        // Leave on the cycle of the final pop so done lands exactly one cycle after it.
        if (!inflight_q && (fifo_empty || ((fifo_count == CNT_BITS'(1)) && pop)))
          state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      type_q     <= IFMAP;
      addr_q     <= '0;
      num_x_q    <= '0;
      num_y_q    <= '0;
      words_q    <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      wi_q       <= '0;
      xi_q       <= '0;
      yi_q       <= '0;
      ptag_x_q   <= '0;
      ptag_y_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= sram_ren;
      if (accept) begin
        type_q  <= stream_e'(cmd_type);
        addr_q  <= cmd_base_addr;
        num_x_q <= cmd_num_x;
        num_y_q <= cmd_num_y;
        words_q <= cmd_words;
        x0_q    <= cmd_tag_x0;
        y0_q    <= cmd_tag_y0;
        wi_q    <= '0;
        xi_q    <= '0;
        yi_q    <= '0;
      end else if (sram_ren) begin
        addr_q   <= addr_q + ADDR_BITS'(1);
        ptag_x_q <= x0_q + xi_q;
        ptag_y_q <= y0_q + yi_q;
        if (last_w) begin
          wi_q <= '0;
          if (last_x) begin
            xi_q <= '0;
            yi_q <= yi_q + YID_BITS'(1);
          end else begin
            xi_q <= xi_q + XID_BITS'(1);
          end
        end else begin
          wi_q <= wi_q + WCNT_BITS'(1);
        end
      end
    end
  end

  assign GLB_ifmap_valid  = sel_valid && (type_q == IFMAP);
  assign GLB_filter_valid = sel_valid && (type_q == FILTER);
  assign GLB_ipsum_valid  = sel_valid && (type_q == IPSUM);
  assign GLB_data_in      = sel_valid ? head_data : '0;

  assign ifmap_tag_X  = GLB_ifmap_valid  ? head_x : '0;
  assign ifmap_tag_Y  = GLB_ifmap_valid  ? head_y : '0;
  assign filter_tag_X = GLB_filter_valid ? head_x : '0;
  assign filter_tag_Y = GLB_filter_valid ? head_y : '0;
  assign ipsum_tag_X  = GLB_ipsum_valid  ? head_x : '0;
  assign ipsum_tag_Y  = GLB_ipsum_valid  ? head_y : '0;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_glb_pe_feeder.sv
// Randomized scoreboard bench for glb_pe_feeder against a loop-nest reference model.
module tb_glb_pe_feeder;

  localparam int DW = 32;
  localparam int XW = 4;
  localparam int YW = 4;
  localparam int AW = 16;
  localparam int CW = 8;
  localparam int W  = 2 + DW + XW + YW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_type = '0;
  logic [AW-1:0] cmd_base_addr = '0;
  logic [XW-1:0] cmd_num_x = '0;
  logic [YW-1:0] cmd_num_y = '0;
  logic [CW-1:0] cmd_words = '0;
  logic [XW-1:0] cmd_tag_x0 = '0;
  logic [YW-1:0] cmd_tag_y0 = '0;
  logic          sram_ren;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_rdata = '0;
  logic          GLB_ifmap_valid, GLB_filter_valid, GLB_ipsum_valid;
  logic          GLB_ifmap_ready = 1'b0, GLB_filter_ready = 1'b0, GLB_ipsum_ready = 1'b0;
  logic [DW-1:0] GLB_data_in;
  logic [XW-1:0] ifmap_tag_X, filter_tag_X, ipsum_tag_X;
  logic [YW-1:0] ifmap_tag_Y, filter_tag_Y, ipsum_tag_Y;
  logic          busy, done;
  logic [1:0]    dbg_state;

  glb_pe_feeder #(.DATA_SIZE(DW), .XID_BITS(XW), .YID_BITS(YW), .ADDR_BITS(AW), .WCNT_BITS(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_base_addr(cmd_base_addr), .cmd_num_x(cmd_num_x), .cmd_num_y(cmd_num_y),
    .cmd_words(cmd_words), .cmd_tag_x0(cmd_tag_x0), .cmd_tag_y0(cmd_tag_y0),
    .sram_ren(sram_ren), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .GLB_ifmap_valid(GLB_ifmap_valid), .GLB_ifmap_ready(GLB_ifmap_ready),
    .GLB_filter_valid(GLB_filter_valid), .GLB_filter_ready(GLB_filter_ready),
    .GLB_ipsum_valid(GLB_ipsum_valid), .GLB_ipsum_ready(GLB_ipsum_ready),
    .GLB_data_in(GLB_data_in),
    .ifmap_tag_X(ifmap_tag_X), .filter_tag_X(filter_tag_X), .ipsum_tag_X(ipsum_tag_X),
    .ifmap_tag_Y(ifmap_tag_Y), .filter_tag_Y(filter_tag_Y), .ipsum_tag_Y(ipsum_tag_Y),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SRAM model ----------------
  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return {~a, a ^ 16'hC3A5};
  endfunction

  always @(posedge clk) if (sram_ren) sram_rdata <= mem_f(sram_addr);

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int cmd_cyc = 0;
  int last_hs_cyc = 0;
  int hs_count = 0;
  int ren_total = 0;
  int hs_total = 0;
  int max_out = 0;
  int ready_mode = 0;
  logic [1:0] cur_type = 2'd3;
  bit first_pending = 0;
  bit busy_pending = 0;
  bit expect_done = 0;
  bit null_cmd = 0;
  bit chk_ready_next = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- ready driver ----------------
  initial begin
    logic sel_r;
    int d;
    forever begin
      @(posedge clk);
      #2;
      d = cyc - cmd_cyc;
      case (ready_mode)
        0:       sel_r = 1'b1;
        1:       sel_r = 1'($urandom_range(0, 1));
        default: sel_r = (d < 11) ? d[0] : ((d < 16) ? 1'b0 : 1'b1);
      endcase
      GLB_ifmap_ready  = (cur_type == 2'd0) ? sel_r : 1'($urandom_range(0, 1));
      GLB_filter_ready = (cur_type == 2'd1) ? sel_r : 1'($urandom_range(0, 1));
      GLB_ipsum_ready  = (cur_type == 2'd2) ? sel_r : 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [1:0] t, input logic [AW-1:0] base, input logic [XW-1:0] nx,
                          input logic [YW-1:0] ny, input logic [CW-1:0] nw,
                          input logic [XW-1:0] x0, input logic [YW-1:0] y0);
    int guard;
    logic [AW-1:0] a;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) check("cmd_ready_wait", 0, 1);
    cmd_type = t; cmd_base_addr = base; cmd_num_x = nx; cmd_num_y = ny;
    cmd_words = nw; cmd_tag_x0 = x0; cmd_tag_y0 = y0;
    cmd_valid = 1'b1;
    cmd_cyc = cyc;
    cur_type = t;
    ren_total = 0; hs_total = 0; hs_count = 0; max_out = 0;
    null_cmd = (t == 2'd3) || (nx == 0) || (ny == 0) || (nw == 0);
    if (!null_cmd) begin
      for (int yi = 0; yi < int'(ny); yi++)
        for (int xi = 0; xi < int'(nx); xi++)
          for (int wi = 0; wi < int'(nw); wi++) begin
            a = base + AW'((yi * int'(nx) + xi) * int'(nw) + wi);
            exp_q.push_back({t, mem_f(a), XW'(x0 + XW'(xi)), YW'(y0 + YW'(yi))});
          end
    end
    first_pending = !null_cmd;
    busy_pending = 1;
    expect_done = 1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_type = $urandom_range(0, 3);
    cmd_base_addr = $urandom;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (expect_done && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (expect_done) begin
      check("done_timeout", 0, 1);
      expect_done = 0;
      exp_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  logic [DW+XW+YW:0] prev_hold;
  bit stall_q = 0;

  always @(negedge clk) begin
    logic [2:0] vv;
    logic [2:0] rr;
    logic [XW-1:0] tx [3];
    logic [YW-1:0] ty [3];
    logic quiet;
    logic sv, sr;
    logic [1:0] ch_seen;
    logic [W-1:0] e;
    if (rst) begin
      stall_q = 0;
    end else begin
      vv = {GLB_ipsum_valid, GLB_filter_valid, GLB_ifmap_valid};
      rr = {GLB_ipsum_ready, GLB_filter_ready, GLB_ifmap_ready};
      tx[0] = ifmap_tag_X; tx[1] = filter_tag_X; tx[2] = ipsum_tag_X;
      ty[0] = ifmap_tag_Y; ty[1] = filter_tag_Y; ty[2] = ipsum_tag_Y;
      quiet = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (c != int'(cur_type)) quiet |= vv[c] | (|tx[c]) | (|ty[c]);
        else if (!vv[c]) quiet |= (|tx[c]) | (|ty[c]);
      end
      if (vv == 3'b000) quiet |= |GLB_data_in;
      check("channel_quiet", quiet, 0);

      sv = (cur_type != 2'd3) ? vv[cur_type] : 1'b0;
      sr = (cur_type != 2'd3) ? rr[cur_type] : 1'b0;
      ch_seen = vv[0] ? 2'd0 : (vv[1] ? 2'd1 : 2'd2);

      if (busy_pending && cyc == cmd_cyc + 1) begin
        check("busy_cycle1", busy, !null_cmd);
        busy_pending = 0;
      end
      if (stall_q)
        check("stall_hold", {sv, GLB_data_in, tx[ch_seen], ty[ch_seen]}, {1'b1, prev_hold[DW+XW+YW-1:0]});
      if (sv && first_pending) begin
        check("first_valid_lat", cyc - cmd_cyc, 3);
        first_pending = 0;
      end
      if (sv && sr) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("word", {ch_seen, GLB_data_in, tx[ch_seen], ty[ch_seen]}, e);
        end
        last_hs_cyc = cyc;
        hs_total++;
        hs_count++;
      end
      stall_q = sv && !sr;
      prev_hold = {sv, GLB_data_in, tx[ch_seen], ty[ch_seen]};

      if (sram_ren) ren_total++;
      if (ren_total - hs_total > max_out) max_out = ren_total - hs_total;

      if (chk_ready_next) begin
        check("ready_after_done", cmd_ready, 1);
        chk_ready_next = 0;
      end
      if (done) begin
        if (!expect_done) begin
          check("spurious_done", 1, 0);
        end else begin
          check("done_lat", cyc, null_cmd ? cmd_cyc + 1 : last_hs_cyc + 1);
          check("drained", exp_q.size(), 0);
          check("busy_at_done", busy, 0);
          check("max_outstanding", max_out <= 2, 1);
          if (null_cmd) check("null_no_ren", ren_total, 0);
          expect_done = 0;
          chk_ready_next = 1;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_outputs", {GLB_ifmap_valid, GLB_filter_valid, GLB_ipsum_valid, GLB_data_in,
                          sram_ren, sram_addr, busy, done}, 0);
    check("rst_tags", {ifmap_tag_X, filter_tag_X, ipsum_tag_X, ifmap_tag_Y, filter_tag_Y, ipsum_tag_Y}, 0);

    ready_mode = 0;
    send_cmd(2'd0, 16'h0010, 4'd2, 4'd1, 8'd3, 4'd4, 4'd1);
    wait_done();

    ready_mode = 2;
    send_cmd(2'd1, 16'h0100, 4'd2, 4'd2, 8'd2, 4'd1, 4'd2);
    wait_done();

    ready_mode = 1;
    send_cmd(2'd2, 16'h0200, 4'd2, 4'd1, 8'd1, 4'hF, 4'd3);
    wait_done();

    send_cmd(2'd3, 16'h0300, 4'd2, 4'd2, 8'd2, 4'd0, 4'd0);
    wait_done();
    send_cmd(2'd0, 16'h0400, 4'd2, 4'd0, 8'd2, 4'd0, 4'd0);
    wait_done();
    send_cmd(2'd1, 16'h0480, 4'd1, 4'd1, 8'd0, 4'd0, 4'd0);
    wait_done();

    // Reset partway through a 10-word transfer.
    ready_mode = 0;
    send_cmd(2'd0, 16'h0600, 4'd5, 4'd1, 8'd2, 4'd0, 4'd0);
    guard = 0;
    while (hs_count < 3 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("reset_reach_3", hs_count >= 3, 1);
    rst = 1'b1;
    exp_q.delete();
    expect_done = 0;
    first_pending = 0;
    busy_pending = 0;
    @(posedge clk);
    #1;
    check("rst_mid_valids", {GLB_ifmap_valid, GLB_filter_valid, GLB_ipsum_valid}, 0);
    check("rst_mid_state", {busy, done, cmd_ready, dbg_state}, {1'b0, 1'b0, 1'b1, 2'd0});
    rst = 1'b0;
    repeat (6) @(negedge clk);

    ready_mode = 1;
    send_cmd(2'd1, 16'h0700, 4'd2, 4'd1, 8'd5, 4'd6, 4'd9);
    wait_done();

    for (int k = 0; k < 10; k++) begin
      ready_mode = $urandom_range(0, 1);
      send_cmd((k % 4 == 3) ? 2'd3 : 2'($urandom_range(0, 2)), 16'($urandom),
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 8'($urandom_range(0, 4)),
               4'($urandom), 4'($urandom));
      wait_done();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
